// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter for one shared RAM slave. The first request
// from idle is granted; simultaneous requests alternate round-robin.
// A master holds the bus until its cyc drops. One idle cycle separates
// ownerships. An 8-bit wait counter returns err when the slave stalls.
// Ports: clk, rst (async, active-low); m0_*/m1_* master side
// (cyc/stb/we/adr/dat in, ack/err/dat out); s_* slave side.
module wb_arbiter2 #(
  parameter int DW        = 32,
  parameter int TO_CYCLES = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [DW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [DW-1:0] m0_dat_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [DW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [DW-1:0] m1_dat_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [DW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic          s_ack_i,
  input  logic [DW-1:0] s_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS0 = 2'd1,
    BUS1 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;

  logic sel1;
  logic cyc_sel;
  logic stb_sel;
  logic tmo;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = m0_adr_i;
    s_dat_o  = m0_dat_i;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    tmo      = 1'b0;
    sel1     = (state_q == BUS1);
    cyc_sel  = sel1 ? m1_cyc_i : m0_cyc_i;
    stb_sel  = sel1 ? m1_stb_i : m0_stb_i;

    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        // last_q=1 means m1 was served last, so m0 wins a tie
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? BUS0 : BUS1;
          last_d  = ~last_q;
        end else if (m0_cyc_i) begin
          state_d = BUS0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = BUS1;
          last_d  = 1'b1;
        end
      end
      BUS0, BUS1: begin
        // ack in the expiry cycle takes priority over the error
        tmo     = (cnt_q == 8'(TO_CYCLES)) && !s_ack_i;
        s_cyc_o = cyc_sel;
        s_stb_o = stb_sel && !tmo;
        s_we_o  = sel1 ? m1_we_i  : m0_we_i;
        s_adr_o = sel1 ? m1_adr_i : m0_adr_i;
        s_dat_o = sel1 ? m1_dat_i : m0_dat_i;
        if (sel1) begin
          m1_ack_o = s_ack_i;
          m1_err_o = tmo;
        end else begin
          m0_ack_o = s_ack_i;
          m0_err_o = tmo;
        end
        if (s_ack_i || tmo) begin
          cnt_d = 8'd0;
        end else if (s_stb_o) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (!cyc_sel) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: a cycle table for arbitration
// and data paths, plus hand sequences for timeout and async reset.
module tb_wb_arbiter2;

  localparam logic [31:0] A   = 32'h0000_0020;
  localparam logic [31:0] B   = 32'h0000_0010;
  localparam logic [31:0] D0  = 32'h0BAD_F00D;
  localparam logic [31:0] D1  = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_cyc, m1_cyc;
  logic        m0_stb, m1_stb;
  logic        m0_we, m1_we;
  logic [31:0] m0_adr, m1_adr;
  logic [31:0] m0_dat, m1_dat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rd, m1_rd;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_wd, s_rd;

  assign m0_stb = m0_cyc;
  assign m1_stb = m1_cyc;
  assign m0_we  = 1'b0;
  assign m1_we  = 1'b1;
  assign m1_adr = B;
  assign m0_dat = D0;
  assign m1_dat = D1;

  wb_arbiter2 #(.DW(32), .TO_CYCLES(15)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rd),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rd),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_wd),
    .s_ack_i(s_ack), .s_dat_i(s_rd)
  );

  typedef struct {
    logic [1:0]  cyc;
    logic [31:0] a0;
    logic        ack;
    logic [31:0] sdat;
    logic        ecyc;
    logic        estb;
    logic        ewe;
    logic [31:0] eadr;
    logic [31:0] ewd;
    logic [1:0]  mack;
  } vec_t;

  vec_t vt[20];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(
    logic [1:0] cyc, logic [31:0] a0, logic ack, logic [31:0] sdat,
    logic ecyc, logic estb, logic ewe, logic [31:0] eadr,
    logic [31:0] ewd, logic [1:0] mack);
    vec_t v;
    v.cyc = cyc; v.a0 = a0; v.ack = ack; v.sdat = sdat;
    v.ecyc = ecyc; v.estb = estb; v.ewe = ewe;
    v.eadr = eadr; v.ewd = ewd; v.mack = mack;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    // cyc[1]=m1, cyc[0]=m0; mack same order
    vt[0]  = mk(2'b11, A, 0, 0,   0, 0, 0, 0, 0,  2'b00);
    vt[1]  = mk(2'b11, A, 0, 0,   1, 1, 0, A, D0, 2'b00);
    vt[2]  = mk(2'b11, A, 1, 32'h1234_5678,
                                  1, 1, 0, A, D0, 2'b01);
    vt[3]  = mk(2'b10, A, 0, 0,   0, 0, 0, 0, 0,  2'b00);
    vt[4]  = mk(2'b10, A, 0, 0,   0, 0, 0, 0, 0,  2'b00);
    vt[5]  = mk(2'b10, A, 0, 0,   1, 1, 1, B, D1, 2'b00);
    vt[6]  = mk(2'b10, A, 1, 32'hCAFE_0001,
                                  1, 1, 1, B, D1, 2'b10);
    vt[7]  = mk(2'b00, A, 0, 0,   0, 0, 0, 0, 0,  2'b00);
    vt[8]  = mk(2'b11, A, 0, 0,   0, 0, 0, 0, 0,  2'b00);
    vt[9]  = mk(2'b11, A, 0, 0,   1, 1, 0, A, D0, 2'b00);
    vt[10] = mk(2'b11, A, 1, 32'h0000_55AA,
                                  1, 1, 0, A, D0, 2'b01);
    vt[11] = mk(2'b00, A, 0, 0,   0, 0, 0, 0, 0,  2'b00);
    vt[12] = mk(2'b11, A, 1, 32'h7777_0000,
                                  0, 0, 0, 0, 0,  2'b00);
    vt[13] = mk(2'b11, A, 0, 0,   1, 1, 1, B, D1, 2'b00);
    vt[14] = mk(2'b11, A, 1, 0,   1, 1, 1, B, D1, 2'b10);
    vt[15] = mk(2'b01, A, 0, 0,   0, 0, 0, 0, 0,  2'b00);
    vt[16] = mk(2'b01, B, 0, 0,   0, 0, 0, 0, 0,  2'b00);
    vt[17] = mk(2'b01, B, 0, 0,   1, 1, 0, B, D0, 2'b00);
    vt[18] = mk(2'b01, B, 1, D1,  1, 1, 0, B, D0, 2'b01);
    vt[19] = mk(2'b00, B, 0, 0,   0, 0, 0, 0, 0,  2'b00);

    rst = 1'b0;
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    m0_adr = A; s_ack = 1'b1; s_rd = 32'h0;
    #3;
    chk("rst_scyc", 32'(s_cyc), 0);
    chk("rst_sstb", 32'(s_stb), 0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 0);
    chk("rst_errs", {30'd0, m1_err, m0_err}, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hold_scyc", 32'(s_cyc), 0);
    @(negedge clk);
    m0_cyc = 1'b0; m1_cyc = 1'b0; s_ack = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      m0_cyc = vt[i].cyc[0];
      m1_cyc = vt[i].cyc[1];
      m0_adr = vt[i].a0;
      s_ack  = vt[i].ack;
      s_rd   = vt[i].sdat;
      #1;
      chk($sformatf("v%0d_scyc", i), 32'(s_cyc), 32'(vt[i].ecyc));
      chk($sformatf("v%0d_sstb", i), 32'(s_stb), 32'(vt[i].estb));
      chk($sformatf("v%0d_ack", i), {30'd0, m1_ack, m0_ack},
          {30'd0, vt[i].mack});
      chk($sformatf("v%0d_err", i), {30'd0, m1_err, m0_err}, 0);
      chk($sformatf("v%0d_m0rd", i), m0_rd, vt[i].sdat);
      chk($sformatf("v%0d_m1rd", i), m1_rd, vt[i].sdat);
      if (vt[i].ecyc) begin
        chk($sformatf("v%0d_swe", i), 32'(s_we), 32'(vt[i].ewe));
        chk($sformatf("v%0d_sadr", i), s_adr, vt[i].eadr);
        chk($sformatf("v%0d_swd", i), s_wd, vt[i].ewd);
      end
    end

    // slave never acks: err in the 15th cycle after stb rises
    @(negedge clk);
    m0_cyc = 1'b1; m0_adr = A; s_ack = 1'b0;
    #1;
    chk("to_idle_stb", 32'(s_stb), 0);
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      #1;
      chk($sformatf("to_w%0d_stb", j), 32'(s_stb), 1);
      chk($sformatf("to_w%0d_err", j), 32'(m0_err), 0);
    end
    @(negedge clk);
    #1;
    chk("to_err", 32'(m0_err), 1);
    chk("to_stb", 32'(s_stb), 0);
    chk("to_ack", 32'(m0_ack), 0);
    chk("to_cyc", 32'(s_cyc), 1);
    @(negedge clk);
    #1;
    chk("to_after_err", 32'(m0_err), 0);
    chk("to_after_stb", 32'(s_stb), 1);
    @(negedge clk);
    m0_cyc = 1'b0;
    @(negedge clk);

    // ack lands on the expiry cycle: ack wins
    @(negedge clk);
    m0_cyc = 1'b1;
    repeat (15) @(negedge clk);
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    chk("race_ack", 32'(m0_ack), 1);
    chk("race_err", 32'(m0_err), 0);
    chk("race_stb", 32'(s_stb), 1);
    @(negedge clk);
    s_ack = 1'b0;
    #1;
    chk("race_next_err", 32'(m0_err), 0);
    chk("race_next_stb", 32'(s_stb), 1);
    @(negedge clk);
    m0_cyc = 1'b0;
    @(negedge clk);

    // async reset mid-transfer
    @(negedge clk);
    m0_cyc = 1'b1;
    @(negedge clk);
    #1;
    chk("ar_pre_cyc", 32'(s_cyc), 1);
    #1;
    rst = 1'b0;
    s_ack = 1'b1;
    #1;
    chk("ar_cyc", 32'(s_cyc), 0);
    chk("ar_stb", 32'(s_stb), 0);
    chk("ar_ack", {30'd0, m1_ack, m0_ack}, 0);
    @(negedge clk);
    rst = 1'b1;
    m0_cyc = 1'b0; m1_cyc = 1'b1; s_ack = 1'b0;
    #1;
    chk("ar_rel_cyc", 32'(s_cyc), 0);
    @(negedge clk);
    #1;
    chk("ar_m1_cyc", 32'(s_cyc), 1);
    chk("ar_m1_adr", s_adr, B);
    chk("ar_m1_we", 32'(s_we), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
